load_store_unit: RTL

//  Memory-stage data-memory access unit; source of the load data that writeback muxes against the ALU result.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access-size codes, FSM states,
// and the access legality check used at issue time.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsuStateT;

    // Unsigned sizes exist only for loads; any code outside the five legal ones faults.
    function automatic logic accessFault(
        input logic [2:0] funct3,
        input logic [1:0] addrLo,
        input logic       isRead,
        input logic       isWrite
    );
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addrLo[0];
            F3_W:    bad = |addrLo;
            F3_BU:   bad = isWrite;
            F3_HU:   bad = isWrite | addrLo[0];
            default: bad = 1'b1;
        endcase
        return bad | (isRead & isWrite);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for the load/store unit: store lane replication with byte enables,
// and load lane extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  storeFunct3,
    input  logic [1:0]  storeAddrLo,
    input  logic [31:0] storeData,
    output logic [3:0]  storeBe,
    output logic [31:0] storeLaneData,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadAddrLo,
    input  logic [31:0] loadWord,
    output logic [31:0] loadData
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        storeBe       = 4'b1111;
        storeLaneData = storeData;
        case (storeFunct3)
            F3_B: begin
                storeBe       = 4'b0001 << storeAddrLo;
                storeLaneData = {4{storeData[7:0]}};
            end
            F3_H: begin
                storeBe       = storeAddrLo[1] ? 4'b1100 : 4'b0011;
                storeLaneData = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (loadAddrLo)
            2'd0:    loadByte = loadWord[7:0];
            2'd1:    loadByte = loadWord[15:8];
            2'd2:    loadByte = loadWord[23:16];
            default: loadByte = loadWord[31:24];
        endcase
        loadHalf = loadAddrLo[1] ? loadWord[31:16] : loadWord[15:0];

        case (loadFunct3)
            F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
            F3_BU:   loadData = {24'b0, loadByte};
            F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_HU:   loadData = {16'b0, loadHalf};
            default: loadData = loadWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: validates the request, runs a req/ack access to data memory
// with a timeout, stalls the pipeline meanwhile and returns extended load data.
//
//  state    | meaning
//  LSU_IDLE | no access in flight; a legal op stalls and launches, an illegal one pulses FaultM
//  LSU_WAIT | mem_req high, fields frozen, waiting for mem_ack or the timeout
//  LSU_DONE | one cycle with stall released so the instruction advances; inputs ignored
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsuStateT         state;
    lsuStateT         stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [2:0]       funct3Q;
    logic [1:0]       addrLoQ;

    logic        opReq;
    logic        opFault;
    logic        startAccess;
    logic        faultSet;
    logic        finishAck;
    logic        finishTimeout;
    logic [3:0]  storeBe;
    logic [31:0] storeLaneData;
    logic [31:0] loadData;

    assign opReq   = MemReadM | MemWriteM;
    assign opFault = accessFault(Funct3M, ALU_ResultM[1:0], MemReadM, MemWriteM);
    assign mem_req = (state == LSU_WAIT);

    lsu_align uAlign (
        .storeFunct3   (Funct3M),
        .storeAddrLo   (ALU_ResultM[1:0]),
        .storeData     (WriteDataM),
        .storeBe       (storeBe),
        .storeLaneData (storeLaneData),
        .loadFunct3    (funct3Q),
        .loadAddrLo    (addrLoQ),
        .loadWord      (mem_rdata),
        .loadData      (loadData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LSU_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        StallM        = 1'b0;
        startAccess   = 1'b0;
        faultSet      = 1'b0;
        finishAck     = 1'b0;
        finishTimeout = 1'b0;
        unique case (state)
            LSU_IDLE: begin
                if (opReq) begin
                    if (opFault) begin
                        faultSet = 1'b1;
                    end else begin
                        StallM      = 1'b1;
                        startAccess = 1'b1;
                        stateNext   = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                StallM = 1'b1;
                // An ack landing on the last counted cycle still wins over the timeout.
                if (mem_ack) begin
                    finishAck = 1'b1;
                    stateNext = LSU_DONE;
                end else if (waitCnt == CNT_LAST) begin
                    finishTimeout = 1'b1;
                    stateNext     = LSU_DONE;
                end
            end
            LSU_DONE: stateNext = LSU_IDLE;
            default:  stateNext = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            funct3Q   <= '0;
            addrLoQ   <= '0;
            waitCnt   <= '0;
            ReadDataM <= '0;
            FaultM    <= 1'b0;
            BusErrM   <= 1'b0;
        end else begin
            FaultM  <= faultSet;
            BusErrM <= finishTimeout;

            if (startAccess) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALU_ResultM[31:2], 2'b00};
                mem_be    <= MemWriteM ? storeBe : 4'b1111;
                mem_wdata <= storeLaneData;
                funct3Q   <= Funct3M;
                addrLoQ   <= ALU_ResultM[1:0];
            end

            if (state == LSU_WAIT) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end

            // Stores never touch ReadDataM; an abandoned load returns zero.
            if (finishAck && !mem_we) begin
                ReadDataM <= loadData;
            end else if (finishTimeout && !mem_we) begin
                ReadDataM <= '0;
            end
        end
    end

endmodule
